mem_port_arbiter: RTL and testbench

//  - Shares the single-port 16x4 mem_block (clka/ena/wea/addra/dina/douta) among NREQ requesters.
//  - Per-cycle arbitration with a registered memory command stage and a read-return pipeline

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/arb_rr_pick.sv | 39 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults and types for the memory port arbiter.
// Holds default widths, the read-return tag bundle and a small index helper.
package mem_arb_pkg;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_RD_LAT = 1;

    // Index width for the default requester count.
    localparam int IDX_W = $clog2(DEF_NREQ);

    // Tag index is sized for the largest supported requester count (8),
    // so one tag type serves every NREQ in 2..8.
    localparam int TAG_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } rd_tag_t;

    // Width of a requester index for a given requester count.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational rotating-priority picker.
// Ports:
//   req  in  NREQ   request vector
//   ptr  in  IDX_W  index where the priority search starts
//   gnt  out NREQ   one-hot grant (zero when req is zero)
//   idx  out IDX_W  index of the granted requester (0 when none)
module arb_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Walk requesters starting at ptr, wrapping at NREQ.
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory among NREQ requesters.
// One access per cycle through a registered command stage; reads are
// returned to their issuer through a tag pipeline of depth RD_LAT+1.
// Config macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// when undefined, fixed priority (lowest index wins) and no pointer register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, req_we              per-requester valid and write-enable
//   req_addr, req_wdata      packed per-requester address and write data
//   gnt                      one-hot combinational grant
//   rvalid, rdata            one-hot read-return strobe and read data
//   ena, wea, addra, dina    memory command outputs
//   douta                    memory read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ena,
    output logic                   wea,
    output logic [ADDR_W-1:0]      addra,
    output logic [DATA_W-1:0]      dina,
    input  logic [DATA_W-1:0]      douta
);

    localparam int PW = idx_width(NREQ);

    logic [NREQ-1:0]   pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     ptr;

    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              ena_q,   ena_d;
    logic              wea_q,   wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q,  dina_d;

    rd_tag_t [RD_LAT:0] tag_q, tag_d;

    arb_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Grant is masked during reset so nothing is accepted at a reset edge.
    assign gnt    = rst ? '0 : pick_gnt;
    assign accept = |gnt;

    assign sel_we    = req_we[pick_idx];
    assign sel_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[pick_idx*DATA_W +: DATA_W];

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (pick_idx == PW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // Command stage: addra/dina hold when idle; dina also holds on reads.
    always_comb begin
        ena_d   = accept;
        wea_d   = accept && sel_we;
        addra_d = addra_q;
        dina_d  = dina_q;
        if (accept) begin
            addra_d = sel_addr;
            if (sel_we) begin
                dina_d = sel_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ena_q   <= 1'b0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
        end else begin
            ena_q   <= ena_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
        end
    end

    // Tag stage 0 lines up with the command stage; the last stage lines
    // up with douta for that read.
    always_comb begin
        tag_d          = tag_q;
        tag_d[0].valid = accept && !sel_we;
        tag_d[0].idx   = TAG_IDX_W'(pick_idx);
        for (int i = 1; i <= RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rvalid[i] = tag_q[RD_LAT].valid &&
                        (tag_q[RD_LAT].idx == TAG_IDX_W'(i));
        end
    end

    assign rdata = douta;
    assign ena   = ena_q;
    assign wea   = wea_q;
    assign addra = addra_q;
    assign dina  = dina_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter
// against a transaction-level model (grant order, memory, read queue).
module tb_mem_port_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 4;
    localparam int DW   = 4;
    localparam int RDL  = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req, req_we, gnt, rvalid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]     rdata, dina, douta;
    logic              ena, wea;
    logic [AW-1:0]     addra;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .ena(ena), .wea(wea),
        .addra(addra), .dina(dina), .douta(douta)
    );

    // Single-port memory with one cycle read latency.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            else     douta <= mem[addra];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_ptr = 0;
    int m_mem [16];
    bit m_ena = 0, m_wea = 0;
    int m_addra = 0, m_dina = 0;
    int acc_idx = -1;
    typedef struct { int due; int idx; int data; } rd_t;
    rd_t q[$];
    logic [NREQ-1:0] obs_gnt, obs_rvalid;
    logic [DW-1:0]   obs_rdata;
    bit pend [NREQ];

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input bit we,
                           input int a, input int d);
        req[i] = v;
        req_we[i] = we;
        req_addr[i*AW +: AW] = AW'(a);
        req_wdata[i*DW +: DW] = DW'(d);
    endtask

    // One cycle: check outputs at negedge, then advance model at posedge.
    task automatic tick();
        int w, p;
        logic [NREQ-1:0] eg, ev;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        p = m_ptr;
`else
        p = 0;
`endif
        @(negedge clk);
        w = rst ? -1 : pick(req, p);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        obs_gnt = gnt;
        obs_rvalid = rvalid;
        obs_rdata = rdata;
        chk("gnt", gnt, eg);
        chk("ena", ena, m_ena);
        chk("wea", wea, m_wea);
        chk("addra", addra, m_addra);
        chk("dina", dina, m_dina);
        ev = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev[q[0].idx] = 1'b1;
            chk("rvalid", rvalid, ev);
            chk("rdata", rdata, q[0].data);
            void'(q.pop_front());
        end else begin
            chk("rvalid", rvalid, ev);
        end
        @(posedge clk);
        if (rst) begin
            m_ena = 0; m_wea = 0; m_addra = 0; m_dina = 0; m_ptr = 0;
            q.delete();
        end else if (w >= 0) begin
            m_ena = 1;
            m_wea = req_we[w];
            m_addra = int'(req_addr[w*AW +: AW]);
            if (req_we[w]) begin
                m_dina = int'(req_wdata[w*DW +: DW]);
                m_mem[m_addra] = m_dina;
            end else begin
                q.push_back('{cyc + RDL + 1, w, m_mem[m_addra]});
            end
            m_ptr = (w + 1) % NREQ;
        end else begin
            m_ena = 0; m_wea = 0;
        end
        acc_idx = w;
        cyc++;
        #1;
    endtask

    initial begin
        int e;
        rst = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        // Reset with both requesting: no grant, idle command.
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 0, 2, 0);
        tick();
        chk("rst_gnt", obs_gnt, 0);
        tick();
        rst = 1'b0;
        req = '0;
        tick();

        // Fill memory so every later read has known data.
        for (int a = 0; a < 16; a++) begin
            set_req(0, 1, 1, a, (a * 7 + 3) & 15);
            tick();
        end
        req = '0;
        tick();

        // Write then read-back of the same address.
        set_req(0, 1, 1, 3, 'hA);
        tick();
        set_req(0, 1, 0, 3, 0);
        tick();
        req = '0;
        tick();
        tick();
        chk("wr_rd_rvalid", obs_rvalid, 2'b01);
        chk("wr_rd_rdata", obs_rdata, 'hA);

        // Arbitration order from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 0, 2, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
            e = (k % 2) ? 2 : 1;
`else
            e = 1;
`endif
            chk("arb_gnt", obs_gnt, e);
        end
        req = '0;
        tick(); tick(); tick();

        // Write by req1 followed directly by a read from req0.
        set_req(1, 1, 1, 7, 5);
        tick();
        req[1] = 1'b0;
        set_req(0, 1, 0, 7, 0);
        tick();
        req = '0;
        tick();
        tick();
        chk("haz_rvalid", obs_rvalid, 2'b01);
        chk("haz_rdata", obs_rdata, 5);
        chk("haz_mem", mem[7], 5);

        // Reset while a read is in flight.
        set_req(1, 1, 0, 9, 0);
        tick();
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_fl_rvalid", obs_rvalid, 0);
        end
        set_req(0, 1, 0, 4, 0);
        tick();
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1, 0, 5, 0);
        set_req(1, 1, 0, 6, 0);
        tick();
        chk("rst_ptr_gnt", obs_gnt, 2'b01);
        req = '0;
        tick(); tick(); tick();

        // Random traffic with holding requesters and rare resets.
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    set_req(i, 1, 1'($urandom_range(1, 0)),
                            int'($urandom_range(15, 0)),
                            int'($urandom_range(15, 0)));
                    pend[i] = 1;
                end else if (pend[i] && $urandom_range(15, 0) == 0) begin
                    req[i] = 1'b0;
                    pend[i] = 0;
                end
            end
            rst = ($urandom_range(99, 0) == 0);
            tick();
            if (acc_idx >= 0) begin
                req[acc_idx] = 1'b0;
                pend[acc_idx] = 0;
            end
        end
        rst = 1'b0;
        req = '0;
        for (int k = 0; k < 4; k++) tick();
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
